bcd_conv_arbiter: RTL

//  Shares one iterative (one shift per clock) double-dabble binary-to-BCD engine

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_dabble_step.sv | 26 ++
 rtl/bcd_conv_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the shared binary-to-BCD conversion engine.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  // Minimum BCD digits needed to hold any width-bit binary value (log10(2) ~ 0.301).
  function automatic int bcd_digits(input int width);
    return (width * 301 + 999) / 1000;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift the
// whole {bcd, binary} register left by one bit.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic [DIGITS*BCD_W+WIDTH-1:0] din,
  output logic [DIGITS*BCD_W+WIDTH-1:0] dout
);

  logic [DIGITS*BCD_W+WIDTH-1:0] adj;

  always_comb begin
    adj = din;
    for (int d = 0; d < DIGITS; d++) begin
      if (adj[WIDTH + d*BCD_W +: BCD_W] >= 4'd5) begin
        adj[WIDTH + d*BCD_W +: BCD_W] = adj[WIDTH + d*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

  assign dout = adj << 1;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared iterative binary-to-BCD converter: arbitrates NUM_REQ
// requesters onto one double-dabble engine that retires one bit per clock.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int DIGITS  = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]                    req_data,
  output logic [NUM_REQ-1:0]                          req_ready,
  output logic                                        rsp_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [DIGITS*BCD_W-1:0]                     rsp_bcd,
  input  logic                                        rsp_ready,
  output logic                                        busy
);

  localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int REG_W = DIGITS * BCD_W + WIDTH;

  if (DIGITS < bcd_digits(WIDTH)) begin : g_digits_check
    $error("bcd_conv_arbiter: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. Requesters hold req_valid/req_data until accepted and never derive
  // req_valid from req_ready; rsp_valid/rsp_id/rsp_bcd hold until rsp_ready.

  state_t             state, state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     grant;
  logic               grant_vld;
  logic               accept;
  logic               last_iter;
  logic [CNT_W-1:0]   iter;
  logic [REG_W-1:0]   sreg;
  logic [REG_W-1:0]   sreg_step;

  bcd_dabble_step #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_step (
    .din  (sreg),
    .dout (sreg_step)
  );

  // Descending scan so the candidate nearest the pointer is written last and wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        grant     = IDW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && grant_vld;
  assign last_iter = (iter == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = CONV;
      CONV:    if (last_iter) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      iter      <= '0;
      sreg      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg   <= {{(DIGITS*BCD_W){1'b0}}, req_data[int'(grant)*WIDTH +: WIDTH]};
            iter   <= '0;
            rsp_id <= grant;
            ptr    <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
          end
        end
        CONV: begin
          sreg <= sreg_step;
          iter <= iter + CNT_W'(1);
          // The final step's output already holds the finished digits.
          if (last_iter) begin
            rsp_bcd   <= sreg_step[REG_W-1 -: DIGITS*BCD_W];
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
